// File: rtl/interleaver_pkg.sv
// Constants and bank-state encoding shared by the block interleaver and deinterleaver.
package interleaver_pkg;

    localparam int DEF_ROWS = 4;
    localparam int DEF_COLS = 4;
    localparam int BLK      = DEF_ROWS * DEF_COLS;
    localparam int CNT_W    = $clog2(BLK);

    typedef enum logic [1:0] {
        EMPTY    = 2'd0,
        FILLING  = 2'd1,
        FULL     = 2'd2,
        DRAINING = 2'd3
    } bank_state_t;

endpackage

// File: rtl/ilv_addr_gen.sv
// Column-major read permutation: maps the symbol count within a block to the
// row-major storage address. The deinterleaver instantiates it with ROWS/COLS swapped.
module ilv_addr_gen #(
    parameter int ROWS  = 4,
    parameter int COLS  = 4,
    parameter int CNT_W = $clog2(ROWS * COLS)
) (
    input  logic [CNT_W-1:0] cnt,
    output logic [CNT_W-1:0] addr
);

    localparam logic [CNT_W-1:0] ROWS_C = CNT_W'(ROWS);
    localparam logic [CNT_W-1:0] COLS_C = CNT_W'(COLS);

    always_comb begin
        addr = (cnt % ROWS_C) * COLS_C + cnt / ROWS_C;
    end

endmodule

// File: rtl/block_interleaver.sv
// Transmit-side block interleaver: ping-pong buffer written row-major and read
// column-major, with a registered valid/ready output stage.
module block_interleaver
    import interleaver_pkg::*;
#(
    parameter int DATA_W = 1,
    parameter int ROWS   = DEF_ROWS,
    parameter int COLS   = DEF_COLS
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_sop,
    output logic              out_eop
);

    localparam int N_SYM = ROWS * COLS;
    localparam int AW    = $clog2(N_SYM);
    localparam logic [AW-1:0] LAST = AW'(N_SYM - 1);

    bank_state_t       state     [2];
    bank_state_t       state_nxt [2];
    logic              wr_bank, rd_bank;
    logic [AW-1:0]     wr_cnt, rd_cnt, rd_addr;
    logic [DATA_W-1:0] mem [2][N_SYM];
    logic              accept, load, wr_last, rd_last;

    ilv_addr_gen #(
        .ROWS  (ROWS),
        .COLS  (COLS),
        .CNT_W (AW)
    ) u_addr_gen (
        .cnt  (rd_cnt),
        .addr (rd_addr)
    );

    always_comb begin
        in_ready = (state[wr_bank] != FULL) && (state[wr_bank] != DRAINING);
        accept   = in_valid && in_ready;
        wr_last  = (wr_cnt == LAST);
        rd_last  = (rd_cnt == LAST);
        load     = ((state[rd_bank] == FULL) || (state[rd_bank] == DRAINING))
                   && (!out_valid || out_ready);
    end

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    // Writer and reader never touch the same bank in one cycle: the writer needs
    // EMPTY/FILLING, the reader needs FULL/DRAINING.
    always_comb begin
        state_nxt = state;
        if (accept) state_nxt[wr_bank] = wr_last ? FULL : FILLING;
        if (load)   state_nxt[rd_bank] = rd_last ? EMPTY : DRAINING;
    end

    // NOTE: sequential state uses non-blocking assignments; the comb block above uses blocking.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= '{default: EMPTY};
            wr_bank   <= 1'b0;
            rd_bank   <= 1'b0;
            wr_cnt    <= '0;
            rd_cnt    <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sop   <= 1'b0;
            out_eop   <= 1'b0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                wr_cnt <= wr_last ? '0 : wr_cnt + 1'b1;
                if (wr_last) wr_bank <= ~wr_bank;
            end
            if (load) begin
                out_valid <= 1'b1;
                out_data  <= mem[rd_bank][rd_addr];
                out_sop   <= (rd_cnt == '0);
                out_eop   <= rd_last;
                rd_cnt    <= rd_last ? '0 : rd_cnt + 1'b1;
                if (rd_last) rd_bank <= ~rd_bank;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

    // NOTE: storage is deliberately not reset; the bank states alone decide what is valid.
    always_ff @(posedge clk) begin
        if (accept) mem[wr_bank][wr_cnt] <= in_data;
    end

endmodule

// File: tb/tb_block_interleaver.sv
// Self-checking bench: 4x4 interleaver against a matrix-transpose scoreboard,
// plus a 3x5 -> 5x3 loopback that must reproduce its input.
module tb_block_interleaver;

    localparam int DW  = 4;
    localparam int R   = 4;
    localparam int C   = 4;
    localparam int BLK = R * C;

    localparam int LW   = 8;
    localparam int LR   = 3;
    localparam int LC   = 5;
    localparam int LBLK = LR * LC;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [DW-1:0] in_data = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [DW-1:0] out_data;
    logic          out_sop, out_eop;

    logic          lb_rst = 1'b1;
    logic          lb_in_valid = 1'b0;
    logic          lb_in_ready;
    logic [LW-1:0] lb_in_data = '0;
    logic          mid_valid, mid_ready, mid_sop, mid_eop;
    logic [LW-1:0] mid_data;
    logic          lb_out_valid, lb_out_sop, lb_out_eop;
    logic          lb_out_ready = 1'b0;
    logic [LW-1:0] lb_out_data;

    always #5 clk = ~clk;

    block_interleaver #(.DATA_W(DW), .ROWS(R), .COLS(C)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_sop(out_sop), .out_eop(out_eop)
    );

    block_interleaver #(.DATA_W(LW), .ROWS(LR), .COLS(LC)) lb_a (
        .clk(clk), .rst(lb_rst),
        .in_valid(lb_in_valid), .in_ready(lb_in_ready), .in_data(lb_in_data),
        .out_valid(mid_valid), .out_ready(mid_ready), .out_data(mid_data),
        .out_sop(mid_sop), .out_eop(mid_eop)
    );

    block_interleaver #(.DATA_W(LW), .ROWS(LC), .COLS(LR)) lb_b (
        .clk(clk), .rst(lb_rst),
        .in_valid(mid_valid), .in_ready(mid_ready), .in_data(mid_data),
        .out_valid(lb_out_valid), .out_ready(lb_out_ready), .out_data(lb_out_data),
        .out_sop(lb_out_sop), .out_eop(lb_out_eop)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference model: fill a ROWS x COLS matrix row by row, emit it column by column.
    logic [DW-1:0] mat [R][C];
    logic [DW-1:0] exp_q [$];
    int wr_pos = 0;
    int out_pos = 0;
    int n_in = 0;
    int n_out = 0;

    function automatic void model_reset();
        wr_pos  = 0;
        out_pos = 0;
        exp_q.delete();
    endfunction

    function automatic void model_accept(input logic [DW-1:0] d);
        mat[wr_pos / C][wr_pos % C] = d;
        wr_pos++;
        n_in++;
        if (wr_pos == BLK) begin
            for (int c = 0; c < C; c++)
                for (int r = 0; r < R; r++)
                    exp_q.push_back(mat[r][c]);
            wr_pos = 0;
        end
    endfunction

    task automatic model_output();
        logic [DW-1:0] e;
        if (exp_q.size() == 0) begin
            check("unexpected_output", 32'(out_data), 32'hFFFF_FFFF);
        end else begin
            e = exp_q.pop_front();
            check("out_data", 32'(out_data), 32'(e));
            check("out_sop", 32'(out_sop), 32'(out_pos == 0));
            check("out_eop", 32'(out_eop), 32'(out_pos == BLK - 1));
        end
        out_pos = (out_pos + 1) % BLK;
        n_out++;
    endtask

    // Drive inputs 1 time unit after an edge, log the handshakes that the next edge completes.
    task automatic step(input logic iv, input logic [DW-1:0] d, input logic ordy);
        in_valid  = iv;
        in_data   = d;
        out_ready = ordy;
        #1;
        if (!rst) begin
            if (in_valid && in_ready) model_accept(in_data);
            if (out_valid && out_ready) model_output();
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input int budget);
        for (int i = 0; i < budget && (exp_q.size() != 0 || out_valid); i++)
            step(1'b0, '0, 1'b1);
        check("drain_done", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        int base_out, base_in, stalls, gaps, cyc;
        logic [LW-1:0] lb_q [$];
        int lb_sent, lb_recv, mid_pos, lb_pos;
        logic [LW-1:0] e8;

        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_sop", 32'(out_sop), 32'd0);
        check("rst_out_eop", 32'(out_eop), 32'd0);
        check("rst_out_data", 32'(out_data), 32'd0);
        rst = 1'b0;

        // 1. Single block with latency check
        base_out = n_out;
        for (int i = 0; i < BLK; i++) begin
            step(1'b1, DW'(i), 1'b1);
            if (i == BLK - 2) check("t1_no_early_out", 32'(out_valid), 32'd0);
        end
        check("t1_full_not_loaded", 32'(out_valid), 32'd0);
        step(1'b0, '0, 1'b1);
        check("t1_first_valid", 32'(out_valid), 32'd1);
        check("t1_first_sop", 32'(out_sop), 32'd1);
        check("t1_first_data", 32'(out_data), 32'd0);
        drain(40);
        check("t1_count", 32'(n_out - base_out), 32'(BLK));

        // 2. Continuous stream of 4 blocks
        base_out = n_out;
        stalls = 0;
        gaps = 0;
        for (int i = 0; i < 4 * BLK + 20; i++) begin
            if (i < 4 * BLK && !in_ready) stalls++;
            if (n_out > base_out && n_out - base_out < 4 * BLK && !out_valid) gaps++;
            step(i < 4 * BLK, DW'(i), 1'b1);
        end
        check("t2_in_ready_stalls", 32'(stalls), 32'd0);
        check("t2_output_gaps", 32'(gaps), 32'd0);
        check("t2_count", 32'(n_out - base_out), 32'(4 * BLK));

        // 3. Backpressure while block 0 drains
        base_out = n_out;
        base_in = n_in;
        for (int i = 0; i < 3 * BLK; i++)
            step(1'b1, DW'(n_in - base_in), 1'b0);
        check("t3_accepts", 32'(n_in - base_in), 32'(2 * BLK));
        check("t3_in_ready_low", 32'(in_ready), 32'd0);
        check("t3_out_valid_held", 32'(out_valid), 32'd1);
        check("t3_out_sop_held", 32'(out_sop), 32'd1);
        check("t3_out_data_held", 32'(out_data), 32'd0);
        drain(80);
        check("t3_count", 32'(n_out - base_out), 32'(2 * BLK));

        // 4. Random valid/ready over 100 blocks
        base_in = n_in;
        cyc = 0;
        while (n_in - base_in < 100 * BLK && cyc < 20000) begin
            step((n_in - base_in < 100 * BLK) ? 1'($urandom % 2) : 1'b0,
                 DW'($urandom), 1'($urandom % 2));
            cyc++;
        end
        check("t4_accepts", 32'(n_in - base_in), 32'(100 * BLK));
        drain(200);

        // 5. Reset mid-block while block 0 drains
        for (int i = 0; i < BLK + 7; i++)
            step(1'b1, DW'(i), 1'b1);
        rst = 1'b1;
        step(1'b1, DW'(5), 1'b1);
        model_reset();
        check("t5_out_valid", 32'(out_valid), 32'd0);
        check("t5_in_ready", 32'(in_ready), 32'd1);
        check("t5_out_sop", 32'(out_sop), 32'd0);
        check("t5_out_data", 32'(out_data), 32'd0);
        rst = 1'b0;
        base_out = n_out;
        for (int i = 0; i < BLK; i++)
            step(1'b1, DW'($urandom), 1'b1);
        drain(40);
        check("t5_fresh_count", 32'(n_out - base_out), 32'(BLK));

        // 6. Loopback 3x5 -> 5x3 restores the original order
        repeat (2) @(posedge clk);
        #1;
        lb_rst = 1'b0;
        lb_sent = 0;
        lb_recv = 0;
        mid_pos = 0;
        lb_pos = 0;
        cyc = 0;
        while (lb_recv < 20 * LBLK && cyc < 8000) begin
            lb_in_valid  = (lb_sent < 20 * LBLK) ? 1'($urandom % 2) : 1'b0;
            lb_in_data   = LW'($urandom);
            lb_out_ready = 1'($urandom % 2);
            #1;
            if (lb_in_valid && lb_in_ready) begin
                lb_q.push_back(lb_in_data);
                lb_sent++;
            end
            if (mid_valid && mid_ready) begin
                check("lb_mid_sop", 32'(mid_sop), 32'(mid_pos == 0));
                check("lb_mid_eop", 32'(mid_eop), 32'(mid_pos == LBLK - 1));
                mid_pos = (mid_pos + 1) % LBLK;
            end
            if (lb_out_valid && lb_out_ready) begin
                if (lb_q.size() == 0) begin
                    check("lb_unexpected_output", 32'(lb_out_data), 32'hFFFF_FFFF);
                end else begin
                    e8 = lb_q.pop_front();
                    check("lb_out_data", 32'(lb_out_data), 32'(e8));
                end
                check("lb_out_sop", 32'(lb_out_sop), 32'(lb_pos == 0));
                check("lb_out_eop", 32'(lb_out_eop), 32'(lb_pos == LBLK - 1));
                lb_pos = (lb_pos + 1) % LBLK;
                lb_recv++;
            end
            @(posedge clk);
            #1;
            cyc++;
        end
        check("lb_received", 32'(lb_recv), 32'(20 * LBLK));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
